// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the arbitrated register bank.
package reg_bank_pkg;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF = 4;

   // Ceiling log2, never below 1 so single-entry indices still have a bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import reg_bank_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   localparam int unsigned PW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   winner,
   output logic            any_req
);

   assign any_req = |req;

   // Scan farthest-first so the candidate nearest ptr is assigned last and wins.
   always_comb begin
      winner = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % int'(NREQ)]) begin
            winner = PW'((int'(ptr) + k) % int'(NREQ));
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ clients; round-robin grant, one access per grant.
module reg_bank_arbiter
   import reg_bank_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW   = clog2(DEPTH),
   localparam int unsigned PW   = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*AW-1:0]    addr,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic                  rvalid,
   output logic [WIDTH-1:0]      rdata,
   output logic                  busy
);

   state_e           state_q;
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    win_q;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] bank_q [DEPTH];

   logic [PW-1:0]    winner;
   logic             any_req;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         win_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  win_q   <= winner;
                  we_q    <= we[winner];
                  addr_q  <= addr[int'(winner)*AW +: AW];
                  wdata_q <= wdata[int'(winner)*WIDTH +: WIDTH];
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               if (we_q) bank_q[addr_q] <= wdata_q;
               ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs depend only on registered state, never on the request inputs.
   assign busy   = (state_q == StGrant);
   assign gnt    = busy ? (NREQ'(1) << win_q) : '0;
   assign rvalid = busy && !we_q;
   assign rdata  = rvalid ? bank_q[addr_q] : '0;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed plus randomized bench for reg_bank_arbiter against a transaction-level model.
module tb_reg_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  we = '0;
   logic [7:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  gnt;
   logic        rvalid;
   logic [7:0]  rdata;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   // Model: bank contents and the requester that has first priority next.
   logic [7:0] mbank [4];
   int         mptr;

   reg_bank_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rdata  (rdata),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_rvalid"}, 32'(rvalid), 32'h0);
      check({tag, "_rdata"}, 32'(rdata), 32'h0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
      mptr = 0;
   endtask

   // One arbitration round from IDLE. abort asserts rst during the grant cycle.
   task automatic access(input string tag, input logic [3:0] r, input logic [3:0] w,
                         input logic [7:0] a, input logic [31:0] d, input bit abort);
      int         win;
      bit         wr;
      logic [1:0] ad;
      logic [7:0] dd;
      logic [3:0] one;
      one = 4'b0001;
      req = r; we = w; addr = a; wdata = d;
      step();
      if (r == 4'b0000) begin
         check_idle({tag, "_noreq"});
         return;
      end
      win = -1;
      for (int k = 0; k < 4; k++) begin
         if (win < 0 && r[(mptr + k) % 4]) win = (mptr + k) % 4;
      end
      wr = w[win];
      ad = a[win*2 +: 2];
      dd = d[win*8 +: 8];
      check({tag, "_gnt"}, 32'(gnt), 32'(one << win));
      check({tag, "_busy"}, 32'(busy), 32'h1);
      check({tag, "_rvalid"}, 32'(rvalid), 32'(!wr));
      check({tag, "_rdata"}, 32'(rdata), wr ? 32'h0 : 32'(mbank[ad]));
      // Perturb fields after capture; the granted access must not see them.
      req = 4'($urandom); we = 4'($urandom); addr = 8'($urandom); wdata = 32'hFFFF_FFFF;
      if (abort) rst = 1'b1;
      step();
      if (abort) begin
         rst = 1'b0;
         model_reset();
      end else begin
         if (wr) mbank[ad] = dd;
         mptr = (win + 1) % 4;
      end
      check_idle({tag, "_after"});
   endtask

   initial begin
      model_reset();
      rst = 1'b1; req = 4'b1111;
      step();
      check_idle("rst1");
      step();
      check_idle("rst2");
      rst = 1'b0;

      // Round robin from reset; requester i reads address i (all zero).
      for (int n = 0; n < 8; n++) access("rr", 4'b1111, 4'b0000, 8'b11_10_01_00, 32'h0, 1'b0);

      // Last grant went to 3: skip pattern 0101 gives 0, 2, 0.
      for (int n = 0; n < 3; n++) access("skip", 4'b0101, 4'b0000, 8'h00, 32'h0, 1'b0);

      // Requester 2 writes addr 1 = A5, then reads it back.
      access("wr2", 4'b0100, 4'b0100, 8'b00_01_00_00, 32'h00A5_0000, 1'b0);
      access("rd2", 4'b0100, 4'b0000, 8'b00_01_00_00, 32'h0, 1'b0);

      // Requester 1 writes addr 2 = 3C; wdata turns to FF during its grant.
      access("cap_wr", 4'b0010, 4'b0010, 8'b00_00_10_00, 32'h0000_3C00, 1'b0);
      access("cap_rd", 4'b0001, 4'b0000, 8'b00_00_00_10, 32'h0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         access("rand", 4'($urandom), 4'($urandom), 8'($urandom), $urandom, 1'b0);
      end

      // Make addr 0 nonzero, then abort a write of 77 to it with reset.
      access("pre", 4'b0001, 4'b0001, 8'h00, 32'h0000_0011, 1'b0);
      access("abort", 4'b1000, 4'b1000, 8'h00, 32'h7700_0000, 1'b1);
      access("post_ptr", 4'b1111, 4'b0000, 8'h00, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         access("post_rd", 4'b0001, 4'b0000, 8'(i), 32'h0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of DEPTH x WIDTH D-flip-flop registers among NREQ requesters.
- Round-robin arbitration with a req/gnt handshake; one access (read or write) per grant.
- Sits between several client blocks and the register storage. It sequences all bank updates, so no client drives the flops directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width in bits.
- DEPTH, 4, number of registers in the bank (power of 2).
- AW, log2(DEPTH) = 2, address width (derived localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. Sampled only on the rising edge of clk.
- req  input  NREQ  per-requester access request, level.
- we  input  NREQ  per-requester write enable (1 = write, 0 = read).
- addr  input  NREQ*AW  packed per-requester register address; requester i uses bits [i*AW +: AW].
- wdata  input  NREQ*WIDTH  packed per-requester write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant pulse; the access is performed in this cycle.
- rvalid  output  1  high during a granted read.
- rdata  output  WIDTH  read data; valid when rvalid = 1, otherwise 0.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state <= IDLE; rr pointer <= 0; all bank registers <= 0; latched fields <= 0.
  - gnt = 0, rvalid = 0, rdata = 0, busy = 0 from the following cycle.
- Reset has priority over everything. Asserted while in GRANT, it aborts the access: no bank write occurs and the pending gnt is dropped.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise choose the winner: the first i with req[i] = 1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - Latch winner index, we[winner], addr[winner] and wdata[winner]; go to GRANT.
- GRANT (exactly one cycle):
  - gnt[winner] = 1; busy = 1.
  - Read (latched we = 0): rvalid = 1, rdata = bank[latched addr].
  - Write (latched we = 1): bank[latched addr] <= latched wdata at the edge leaving GRANT; rvalid = 0.
  - At that edge: ptr <= (winner + 1) mod NREQ; state <= IDLE.
- Outputs gnt, rvalid, rdata and busy are decoded from state and latched registers only. There is no combinational path from the req/we/addr/wdata inputs.
- Latency and throughput:
  - req sampled high at edge k gives gnt high during cycle k+1.
  - Maximum rate is one access per 2 cycles.
  - Continuous req from all requesters yields grants 0,1,2,3,0,... after reset.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees its gnt.
  - Fields are captured at the IDLE->GRANT edge. Changes after capture do not affect the granted access.
  - Dropping req before capture withdraws the request with no side effect.
  - A requester still holding req after its gnt is treated as a new request and re-arbitrated.
- Ordering: a write followed by a read of the same address from any requester returns the new data. The write completes before the next IDLE->GRANT capture.
- Fairness: a requester holding req is granted within NREQ grants.
- Addresses are always in range because DEPTH = 2^AW; no error path.

Decomposition:
- Shared package reg_bank_pkg:
  - state enum {IDLE, GRANT}.
  - Default NREQ, WIDTH and DEPTH constants.
  - Helper function for clog2.
- One sub-module, rr_pick: purely combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: winner index, any_req.
- The FSM, latches and bank registers stay in reg_bank_arbiter.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with req = 4'b1111 → gnt = 0, busy = 0, rdata = 0. A read of each address 0..3 afterwards returns 0x00.
- Single write then read: requester 2 writes addr 1 = 0xA5 (gnt[2] one cycle after req), then reads addr 1 → rvalid = 1, rdata = 0xA5 during its gnt.
- Round-robin: req = 4'b1111 held for 8 grants from reset → gnt sequence 0,1,2,3,0,1,2,3, each one cycle wide with one idle cycle between.
- Pointer wrap and skip: after a grant to requester 3, req = 4'b0101 → grant to 0, then 2, then 0.
- Field capture: requester 1 writes addr 2 = 0x3C and changes wdata to 0xFF during its GRANT cycle → a later read of addr 2 returns 0x3C.
- Reset mid-operation: assert rst during a GRANT cycle of a write of 0x77 to addr 0 → addr 0 reads 0x00 afterwards, and the arbiter returns to IDLE with ptr = 0.
